// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// op encoding, sequencer state encoding and the default datapath width.
package mdu_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;
    localparam logic [2:0] MDU_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_MUL = 2'd1,
        RUN_DIV = 2'd2,
        FINISH  = 2'd3
    } mdu_state_e;

    // True for every op the sequencer acts on; NONE and the reserved code are bubbles.
    function automatic logic mdu_op_active(input logic [2:0] op);
        return (op != MDU_NONE) && (op != MDU_RSVD);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate. Used as |x| on the operand side
// (i_neg = signed op & sign bit) and as sign correction on the result side.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Iterative multiply/divide sequencer beside the EX-stage ALU; owns HI/LO.
// Shift-add multiply (64-bit accumulator) and restoring divide, one step per
// cycle, then a single FINISH cycle that applies sign correction and writes HI/LO.
// Optional build macro MDU_EARLY_TERM_EN: multiply leaves RUN_MUL as soon as the
// remaining multiplier bits are all zero (divide timing is unaffected).
module ex_muldiv_sequencer
    import mdu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              mf_req,
    output logic              busy,
    output logic              stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_by_zero
);

    // Iteration count always equals the datapath width.
    localparam int STEPS = DATA_W;
    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    mdu_state_e r_state;
    mdu_state_e w_next;

    logic                r_busy;
    logic                r_dbz;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_acc;      // product accumulator
    logic [2*DATA_W-1:0] r_mcand;    // multiplicand, shifted left each step
    logic [DATA_W-1:0]   r_work;     // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [DATA_W-1:0]   r_divisor;
    logic [DATA_W-1:0]   r_rem;      // partial remainder; always < divisor after a step
    logic [DATA_W-1:0]   r_a_orig;   // unmodified dividend for the divide-by-zero result
    logic                r_b_zero;
    logic                r_is_mul;
    logic                r_sign_q;
    logic                r_sign_r;

    logic                w_accept;
    logic                w_is_mul_op;
    logic                w_is_div_op;
    logic                w_signed_op;
    logic                w_cnt_last;
    logic                w_mul_last;
    logic                w_div_ge;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [DATA_W-1:0]   w_q_fix;
    logic [DATA_W-1:0]   w_r_fix;
    logic [DATA_W-1:0]   w_div_diff;
    logic [DATA_W:0]     w_div_shift;   // 33-bit trial remainder
    logic [2*DATA_W-1:0] w_acc_next;
    logic [2*DATA_W-1:0] w_prod_fix;

    // Ops are only sampled in IDLE; anything presented while busy is held off by stall.
    assign w_accept    = (r_state == IDLE) && op_valid && mdu_op_active(op);
    assign w_is_mul_op = (op == MDU_MULT) || (op == MDU_MULTU);
    assign w_is_div_op = (op == MDU_DIV)  || (op == MDU_DIVU);
    assign w_signed_op = (op == MDU_MULT) || (op == MDU_DIV);

    mdu_sign_fix #(.W(DATA_W)) u_abs_a (
        .i_val (operand_a),
        .i_neg (w_signed_op & operand_a[DATA_W-1]),
        .o_val (w_abs_a)
    );

    mdu_sign_fix #(.W(DATA_W)) u_abs_b (
        .i_val (operand_b),
        .i_neg (w_signed_op & operand_b[DATA_W-1]),
        .o_val (w_abs_b)
    );

    mdu_sign_fix #(.W(2*DATA_W)) u_neg_prod (
        .i_val (r_acc),
        .i_neg (r_sign_q),
        .o_val (w_prod_fix)
    );

    mdu_sign_fix #(.W(DATA_W)) u_neg_quo (
        .i_val (r_work),
        .i_neg (r_sign_q),
        .o_val (w_q_fix)
    );

    mdu_sign_fix #(.W(DATA_W)) u_neg_rem (
        .i_val (r_rem),
        .i_neg (r_sign_r),
        .o_val (w_r_fix)
    );

    assign w_acc_next  = r_work[0] ? (r_acc + r_mcand) : r_acc;
    assign w_div_shift = {r_rem, r_work[DATA_W-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_divisor});
    // When the trial succeeds the difference is below the divisor, so W bits suffice.
    assign w_div_diff  = w_div_shift[DATA_W-1:0] - r_divisor;
    assign w_cnt_last  = (r_cnt == LAST_STEP);

`ifdef MDU_EARLY_TERM_EN
    // Bits above the one consumed this step are what remain after the shift.
    assign w_mul_last = w_cnt_last || (r_work[DATA_W-1:1] == {(DATA_W-1){1'b0}});
`else
    assign w_mul_last = w_cnt_last;
`endif

    assign busy        = r_busy;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;
    assign stall       = r_busy & ((op_valid & mdu_op_active(op)) | mf_req);

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection: accept, iterate, finish
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_mul_op) begin
                    w_next = RUN_MUL;
                end else if (w_accept && w_is_div_op) begin
                    w_next = RUN_DIV;
                end else begin
                    w_next = IDLE;
                end
            end
            RUN_MUL: begin
                if (w_mul_last) begin
                    w_next = FINISH;
                end else begin
                    w_next = RUN_MUL;
                end
            end
            RUN_DIV: begin
                if (w_cnt_last) begin
                    w_next = FINISH;
                end else begin
                    w_next = RUN_DIV;
                end
            end
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, per-step iteration and HI/LO write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= {DATA_W{1'b0}};
            r_lo      <= {DATA_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_acc     <= {(2*DATA_W){1'b0}};
            r_mcand   <= {(2*DATA_W){1'b0}};
            r_work    <= {DATA_W{1'b0}};
            r_divisor <= {DATA_W{1'b0}};
            r_rem     <= {DATA_W{1'b0}};
            r_a_orig  <= {DATA_W{1'b0}};
            r_b_zero  <= 1'b0;
            r_is_mul  <= 1'b0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
        end else begin
            r_dbz <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (op == MDU_MTHI) begin
                            r_hi <= operand_a;
                        end else if (op == MDU_MTLO) begin
                            r_lo <= operand_a;
                        end else begin
                            r_busy    <= 1'b1;
                            r_is_mul  <= w_is_mul_op;
                            r_sign_q  <= w_signed_op & (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
                            r_sign_r  <= w_signed_op & operand_a[DATA_W-1];
                            r_a_orig  <= operand_a;
                            r_b_zero  <= (operand_b == {DATA_W{1'b0}});
                            r_acc     <= {(2*DATA_W){1'b0}};
                            r_mcand   <= {{DATA_W{1'b0}}, w_abs_a};
                            r_work    <= w_is_mul_op ? w_abs_b : w_abs_a;
                            r_divisor <= w_abs_b;
                            r_rem     <= {DATA_W{1'b0}};
                            r_cnt     <= {CNT_W{1'b0}};
                        end
                    end
                end
                RUN_MUL: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= {r_mcand[2*DATA_W-2:0], 1'b0};
                    r_work  <= {1'b0, r_work[DATA_W-1:1]};
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                RUN_DIV: begin
                    r_rem  <= w_div_ge ? w_div_diff : w_div_shift[DATA_W-1:0];
                    r_work <= {r_work[DATA_W-2:0], w_div_ge};
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                FINISH: begin
                    r_busy <= 1'b0;
                    if (r_is_mul) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_b_zero) begin
                        r_hi  <= r_a_orig;
                        r_lo  <= {DATA_W{1'b1}};
                        r_dbz <= 1'b1;
                    end else begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: driver pushes expected HI/LO,
// divide-by-zero flag and completion cycle into a scoreboard; a monitor pops
// and compares whenever busy falls. Expected values come from plain SV
// arithmetic on the operands.
module tb_ex_muldiv_sequencer;
    import mdu_pkg::*;

`ifdef MDU_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        mf_req;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    typedef struct {
        int          id;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          done_cycle;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   n_ops = 0;
    logic prev_busy = 1'b0;

    ex_muldiv_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .mf_req      (mf_req),
        .busy        (busy),
        .stall       (stall),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Reference results straight from the arithmetic definition of each op.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ehi, output logic [31:0] elo, output logic edbz);
        logic [63:0] p;
        longint      sa, sb, q, r;
        edbz = 1'b0;
        ehi  = 32'h0;
        elo  = 32'h0;
        if (o == MDU_MULT) begin
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
            ehi = p[63:32];
            elo = p[31:0];
        end else if (o == MDU_MULTU) begin
            p = {32'h0, a} * {32'h0, b};
            ehi = p[63:32];
            elo = p[31:0];
        end else if (b == 32'h0) begin
            ehi  = a;
            elo  = 32'hFFFF_FFFF;
            edbz = 1'b1;
        end else if (o == MDU_DIV) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            q   = sa / sb;
            r   = sa % sb;
            elo = q[31:0];
            ehi = r[31:0];
        end else begin
            elo = a / b;
            ehi = a % b;
        end
    endtask

    // Edges from acceptance until HI/LO are written.
    function automatic int lat(input logic [2:0] o, input logic [31:0] b);
        logic [31:0] m;
        int          k;
        m = (o == MDU_MULT && b[31]) ? (32'h0 - b) : b;
        k = 1;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
        if (EARLY && (o == MDU_MULT || o == MDU_MULTU)) return k + 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    // Completion monitor: compare HI/LO/div_by_zero and timing when busy falls
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy <= 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion: actual=busy_fell required=no_pending_op");
                end else begin
                    check($sformatf("op%0d_hi", sb_q[0].id), hi, sb_q[0].hi);
                    check($sformatf("op%0d_lo", sb_q[0].id), lo, sb_q[0].lo);
                    check($sformatf("op%0d_dbz", sb_q[0].id), div_by_zero, sb_q[0].dbz);
                    check($sformatf("op%0d_done_cycle", sb_q[0].id), cycle, sb_q[0].done_cycle);
                    void'(sb_q.pop_front());
                end
            end else if (div_by_zero) begin
                checks++;
                failures++;
                $display("FAIL spurious_dbz: actual=1 required=0 at cycle %0d", cycle);
            end
            prev_busy <= busy;
        end
    end

    // Called at a negedge; returns at a negedge with busy low (or after a reported timeout).
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("wait_idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || sb_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy || sb_q.size() != 0) check("wait_done_timeout", 1'b1, 1'b0);
    endtask

    task automatic issue_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_idle();
        model(o, a, b, e.hi, e.lo, e.dbz);
        e.id         = n_ops;
        e.done_cycle = cycle + 1 + lat(o, b);
        n_ops++;
        sb_q.push_back(e);
        op_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(negedge clk);
        op_valid  = 1'b0;
        op        = MDU_NONE;
        operand_a = $urandom;
        operand_b = $urandom;
        check($sformatf("op%0d_busy_after_accept", e.id), busy, 1'b1);
    endtask

    task automatic issue_mt(input logic [2:0] o, input logic [31:0] v);
        logic [31:0] old_hi, old_lo;
        wait_idle();
        old_hi    = hi;
        old_lo    = lo;
        op_valid  = 1'b1;
        op        = o;
        operand_a = v;
        operand_b = $urandom;
        #1;
        check("mt_idle_stall", stall, 1'b0);
        @(negedge clk);
        op_valid = 1'b0;
        op       = MDU_NONE;
        check("mt_busy", busy, 1'b0);
        check("mt_hi", hi, (o == MDU_MTHI) ? v : old_hi);
        check("mt_lo", lo, (o == MDU_MTLO) ? v : old_lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sv_hi, sv_lo, exp_lo, exp_hi, a, b;
        logic        dz;
        int          n;
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op        = MDU_NONE;
        operand_a = 32'h0;
        operand_b = 32'h0;
        mf_req    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_dbz", div_by_zero, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // MTHI in IDLE: immediate write, no busy/stall.
        issue_mt(MDU_MTHI, 32'h0000_1234);
        check("mthi_idle_stall", stall, 1'b0);

        // Directed arithmetic vectors.
        issue_md(MDU_MULT,  32'hFFFF_FFFE, 32'h0000_0003);
        issue_md(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue_md(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
        issue_md(MDU_DIVU,  32'd100,       32'h0000_0000);
        issue_md(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        issue_md(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0000);
        issue_md(MDU_MULTU, 32'hDEAD_BEEF, 32'h0000_0001);
        issue_md(MDU_MULT,  32'h1234_5678, 32'h0000_0000);
        wait_done();

        // MULT followed by MFLO held in EX: stall until HI/LO written.
        a = 32'h0000_0007;
        b = 32'hFFFF_FFFD;
        model(MDU_MULT, a, b, exp_hi, exp_lo, dz);
        issue_md(MDU_MULT, a, b);
        mf_req = 1'b1;
        #1;
        n = 0;
        while (stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mflo_stall_cycles", n, lat(MDU_MULT, b));
        check("mflo_busy_at_release", busy, 1'b0);
        check("mflo_sees_new_lo", lo, exp_lo);
        mf_req = 1'b0;
        wait_done();

        // MTHI presented while a multiply runs: held off, then applied.
        issue_md(MDU_MULTU, 32'h0001_0000, 32'h0001_0000);
        op_valid  = 1'b1;
        op        = MDU_MTHI;
        operand_a = 32'h0000_1234;
        #1;
        check("mthi_busy_stall", stall, 1'b1);
        n = 0;
        while (stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mthi_busy_stall_cycles", n, 33);
        @(negedge clk);
        op_valid = 1'b0;
        op       = MDU_NONE;
        check("mthi_after_mul_hi", hi, 32'h0000_1234);
        check("mthi_after_mul_lo", lo, 32'h0);
        check("mthi_after_mul_busy", busy, 1'b0);

        // Reset during a divide aborts it with no HI/LO update.
        issue_md(MDU_DIV, 32'h7654_3210, 32'h0000_0013);
        repeat (9) @(negedge clk);
        check("pre_reset_busy", busy, 1'b1);
        void'(sb_q.pop_back());
        #2 rst_n = 1'b0;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_stall", stall, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", busy, 1'b0);

        // Randomized mix, including bubbles with op_valid on NONE/reserved codes.
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 9);
            if (n < 8) begin
                issue_md(3'($urandom_range(1, 4)), pick(), pick());
            end else if (n == 8) begin
                issue_mt(($urandom_range(0, 1) == 0) ? MDU_MTHI : MDU_MTLO, $urandom);
            end else begin
                wait_idle();
                sv_hi     = hi;
                sv_lo     = lo;
                op_valid  = 1'b1;
                op        = ($urandom_range(0, 1) == 0) ? MDU_NONE : MDU_RSVD;
                operand_a = $urandom;
                @(negedge clk);
                op_valid = 1'b0;
                op       = MDU_NONE;
                check("bubble_busy", busy, 1'b0);
                check("bubble_hilo", {hi, lo}, {sv_hi, sv_lo});
            end
        end
        wait_done();
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
- Iterative multiply/divide sequencer beside the EX-stage ALU. Owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EX, using operands taken after the ForwardA/ForwardB muxes.
- Runs a 32-step shift-add or restoring-divide loop.
- Raises a pipeline stall while busy and a dependent MDU op or MFHI/MFLO sits in EX.

Parameters:
- DATA_W, 32: operand, HI and LO width.
- STEPS, DATA_W: iteration count. Fixed equal to DATA_W; must not be overridden independently.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  EX holds a valid MDU op this cycle (not a bubble).
- op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- operand_a  in  DATA_W  forwarded rs value (post-ForwardA mux).
- operand_b  in  DATA_W  forwarded rt value (post-ForwardB mux).
- mf_req  in  1  MFHI/MFLO in EX this cycle.
- busy  out  1  iteration in progress.
- stall  out  1  freeze PC, IF/ID and ID/EX; insert bubble into EX/MEM.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.
- div_by_zero  out  1  one-cycle pulse on completion of DIV/DIVU with operand_b = 0.

Behaviour:
- Reset values (async, rst_n low): state IDLE; hi, lo, busy, div_by_zero all 0; counter and work registers 0. Reset asserted mid-operation aborts the operation with no HI/LO update.
- stall = busy & ((op_valid & op != NONE) | mf_req). Purely combinational from registered busy; no dependency on operand values.
- States:
  - IDLE: accepts at a clock edge when op_valid and op is one of 1..6.
  - RUN_MUL / RUN_DIV: one step per cycle; counter counts 0..STEPS-1.
  - FINISH: one cycle; applies sign correction, writes HI/LO, then returns to IDLE.
- IDLE transitions:
  - MTHI/MTLO: write hi/lo at the accepting edge. Stay in IDLE; busy stays 0.
  - MULT/MULTU → RUN_MUL; DIV/DIVU → RUN_DIV.
  - Latch |a| and |b| for signed ops (raw values for unsigned). Record sign_q = a[31]^b[31] and sign_r = a[31]. Clear the accumulator and counter.
- Latency: op accepted at edge E0.
  - busy = 1 from after E0 until after E32.
  - HI/LO written at E33 (FINISH edge); busy drops at E33.
  - A stalled follower is re-presented and accepted at E33 or later. An MFHI held in EX reads new HI in the cycle after E33.
- Multiply: shift-add, 64-bit accumulator. Signed result = two's-complement negation of the 64-bit product when sign_q = 1. HI = [63:32], LO = [31:0].
- Divide: restoring algorithm, 33-bit partial remainder. LO = quotient (negated if sign_q), HI = remainder (negated if sign_r).
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0 (wraps, no trap).
- Divide by zero: runs the full 33 cycles; result HI = operand_a as latched (original signed value), LO = 0xFFFFFFFF; div_by_zero pulses in the cycle after E33.
- op_valid while busy is not sampled. There is no flush or abort input: an accepted op always completes.
- MTHI/MTLO while busy: stalled, then applied after completion (program order preserved).

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined: RUN_MUL exits to FINISH after the step in which the remaining unshifted multiplier bits become all zero. Multiplier 0 or 1 → FINISH after 1 step, so HI/LO are written at E2. Divide timing is unchanged.
- Undefined: fixed 32 steps for every multiply; early-exit logic is absent.

Decomposition:
- Package mdu_pkg: op encoding localparams (MDU_NONE…MDU_MTLO), state enum (IDLE, RUN_MUL, RUN_DIV, FINISH), DATA_W default.
- Sub-module mdu_sign_fix: combinational abs on input and conditional 64-bit/32-bit negate on output. Instantiated for the operand and result paths.

Test Plan:
- MULT a = 0xFFFFFFFE (-2), b = 3 → busy for 33 cycles; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA written at E33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 100, div_by_zero pulse.
- MULT, then MFLO in EX next cycle → stall high exactly until E33; MFLO sees the new LO the cycle after E33.
- MTHI 0x1234 in IDLE → hi = 0x1234 next cycle, busy and stall never asserted. MTHI issued while busy → stalled and applied after the multiply (final HI = 0x1234).
- rst_n pulsed low at step 10 of a DIV → immediate IDLE, hi = lo = 0, busy = 0. With MDU_EARLY_TERM_EN defined: MULTU × 1 → HI/LO written at E2.
